// File: rtl/link_rx_frame_sync.sv
// ============================================================================
//  Module   : link_rx_frame_sync
//  Purpose  : Frame-alignment receiver for the serial PCS link. It hunts for
//             a fixed marker word that recurs every FRAME_LEN words, declares
//             lock after LOCK_CNT consecutive good markers, flywheels across
//             isolated misses and drops lock after UNLOCK_CNT consecutive
//             missed markers. The received stream is re-emitted with a fixed
//             one-word latency and a start-of-frame strobe.
//
//  Ports    : iSclk    in   1      link word clock, rising edge
//             iRstN    in   1      asynchronous active-low reset
//             iD_Link  in   DW     received link word, one per cycle
//             iErrClr  in   1      synchronous clear of oErrCnt
//             oData    out  DW     iD_Link delayed by one cycle
//             oSof     out  1      strobe aligned to the marker slot on oData
//             oSync    out  1      frame lock indicator
//             oState   out  2      0 HUNT, 1 VERIFY, 2 LOCKED
//             oErrCnt  out  ERR_W  saturating link error count
//
//  Options  : LINK_RX_ERRCNT_EN - when defined, the saturating error counter
//             is built and iErrClr clears it. When undefined, oErrCnt is tied
//             to 0 and iErrClr is ignored. The port list is the same.
//
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module link_rx_frame_sync #(
   parameter int              DW         = 20,
   parameter int              FRAME_LEN  = 3900,
   parameter logic [DW-1:0]   MARKER     = {DW{1'b1}},
   parameter int              LOCK_CNT   = 4,
   parameter int              UNLOCK_CNT = 3,
   parameter int              ERR_W      = 16
) (
   input  logic              iSclk,
   input  logic              iRstN,
   input  logic [DW-1:0]     iD_Link,
   input  logic              iErrClr,
   output logic [DW-1:0]     oData,
   output logic              oSof,
   output logic              oSync,
   output logic [1:0]        oState,
   output logic [ERR_W-1:0]  oErrCnt
);

   // -------------------------------------------------------------------------
   // Widths and constants
   // -------------------------------------------------------------------------
   localparam int PW = $clog2(FRAME_LEN + 1);
   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int BW = $clog2(UNLOCK_CNT + 1);

   localparam logic [PW-1:0] C_POS_ONE   = PW'(1);
   localparam logic [PW-1:0] C_POS_FRAME = PW'(FRAME_LEN);
   localparam logic [GW-1:0] C_GOOD_ONE  = GW'(1);
   localparam logic [GW-1:0] C_GOOD_LOCK = GW'(LOCK_CNT);
   localparam logic [BW-1:0] C_BAD_ONE   = BW'(1);
   localparam logic [BW-1:0] C_BAD_LIM   = BW'(UNLOCK_CNT);

   localparam logic [1:0] S_HUNT   = 2'd0;
   localparam logic [1:0] S_VERIFY = 2'd1;
   localparam logic [1:0] S_LOCKED = 2'd2;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [1:0]     r_state;
   logic [PW-1:0]  r_pos;
   logic [GW-1:0]  r_good;
   logic [BW-1:0]  r_bad;
   logic [DW-1:0]  r_data;
   logic           r_sof;
   logic           r_sync;

   logic [1:0]     w_state_nxt;
   logic [PW-1:0]  w_pos_nxt;
   logic [GW-1:0]  w_good_nxt;
   logic [BW-1:0]  w_bad_nxt;
   logic [GW-1:0]  w_good_inc;
   logic [BW-1:0]  w_bad_inc;
   logic           w_mk;
   logic           w_slot;
   logic           w_err_ev;

   assign w_mk       = (iD_Link == MARKER);
   assign w_slot     = (r_pos == C_POS_FRAME);
   assign w_good_inc = r_good + C_GOOD_ONE;
   assign w_bad_inc  = r_bad + C_BAD_ONE;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_good_nxt  = r_good;
      w_bad_nxt   = r_bad;
      w_err_ev    = 1'b0;

      // Free-running position saturates at the slot; the cases below
      // override it with a reload to 1 on realign or on a locked slot.
      if (w_slot) begin
         w_pos_nxt = r_pos;
      end else begin
         w_pos_nxt = r_pos + C_POS_ONE;
      end

      case (r_state)
         S_HUNT: begin
            if (w_mk) begin
               w_pos_nxt  = C_POS_ONE;
               w_good_nxt = C_GOOD_ONE;
               if (LOCK_CNT == 1) begin
                  w_state_nxt = S_LOCKED;
                  w_bad_nxt   = '0;
               end else begin
                  w_state_nxt = S_VERIFY;
               end
            end
         end

         S_VERIFY: begin
            if (w_mk) begin
               w_pos_nxt = C_POS_ONE;
               if (w_slot) begin
                  w_good_nxt = w_good_inc;
                  if (w_good_inc == C_GOOD_LOCK) begin
                     w_state_nxt = S_LOCKED;
                     w_bad_nxt   = '0;
                  end
               end else begin
                  // Marker at the wrong distance: restart the count from
                  // this new candidate alignment.
                  w_good_nxt = C_GOOD_ONE;
               end
            end else if (w_slot) begin
               w_state_nxt = S_HUNT;
               w_good_nxt  = '0;
            end
         end

         S_LOCKED: begin
            // Flywheel: the slot timing never moves while locked, so a
            // spurious marker is only an error and a missing one is
            // tolerated until the miss run reaches the limit.
            w_err_ev = w_slot ^ w_mk;
            if (w_slot) begin
               w_pos_nxt = C_POS_ONE;
               if (w_mk) begin
                  w_bad_nxt = '0;
               end else if (w_bad_inc == C_BAD_LIM) begin
                  w_state_nxt = S_HUNT;
                  w_good_nxt  = '0;
                  w_bad_nxt   = '0;
               end else begin
                  w_bad_nxt = w_bad_inc;
               end
            end
         end

         default: begin
            w_state_nxt = S_HUNT;
            w_good_nxt  = '0;
            w_bad_nxt   = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge iSclk or negedge iRstN) begin
      if (!iRstN) begin
         r_state <= S_HUNT;
         r_pos   <= '0;
         r_good  <= '0;
         r_bad   <= '0;
         r_data  <= '0;
         r_sof   <= 1'b0;
         r_sync  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pos   <= w_pos_nxt;
         r_good  <= w_good_nxt;
         r_bad   <= w_bad_nxt;
         r_data  <= iD_Link;
         // Both strobes use the pre-update state so they line up with the
         // word on oData that was sampled in the same cycle.
         r_sof   <= (r_state == S_LOCKED) && w_slot;
         r_sync  <= (r_state == S_LOCKED);
      end
   end

   assign oData  = r_data;
   assign oSof   = r_sof;
   assign oSync  = r_sync;
   assign oState = r_state;

   // -------------------------------------------------------------------------
   // Optional error counter
   // -------------------------------------------------------------------------
`ifdef LINK_RX_ERRCNT_EN
   logic [ERR_W-1:0] r_err_cnt;

   always_ff @(posedge iSclk or negedge iRstN) begin
      if (!iRstN) begin
         r_err_cnt <= '0;
      end else if (iErrClr) begin
         r_err_cnt <= '0;
      end else if (w_err_ev && (r_err_cnt != {ERR_W{1'b1}})) begin
         r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
   end

   assign oErrCnt = r_err_cnt;
`else
   logic w_unused;
   assign w_unused = &{1'b0, iErrClr, w_err_ev};
   assign oErrCnt  = '0;
`endif

endmodule

`default_nettype wire
